// File: rtl/sid_envelope_mv_pkg.sv
// Shared definitions for the time-multiplexed SID envelope generator.
// Holds the per-voice state encoding, the per-voice register struct, the
// sequencer encoding, the ADSR rate-period table and the exponential divisor.
package sid;

  typedef enum logic [1:0] {
    ATTACK        = 2'd0,
    DECAY_SUSTAIN = 2'd1,
    RELEASE       = 2'd2
  } env_state_t;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic       gate;
    logic [3:0] attack;
    logic [3:0] decay;
    logic [3:0] sustain;
    logic [3:0] release_;
  } envelope_reg_t;

  // SID cycles between rate events, indexed by the 4-bit rate nibble.
  localparam logic [15:0] ENV_RATE_PERIOD [16] = '{
    16'd8,    16'd31,   16'd62,   16'd94,
    16'd148,  16'd219,  16'd266,  16'd312,
    16'd391,  16'd976,  16'd1953, 16'd3125,
    16'd3906, 16'd11719, 16'd19531, 16'd31250
  };

  // Piecewise-linear approximation of the exponential decay/release curve:
  // number of rate events needed per envelope step at the current level.
  function automatic logic [4:0] exp_divisor(input env_state_t st, input logic [7:0] env);
    logic [4:0] d;
    if (st == ATTACK || env >= 8'h5D) d = 5'd1;
    else if (env >= 8'h36)            d = 5'd2;
    else if (env >= 8'h1A)            d = 5'd4;
    else if (env >= 8'h0E)            d = 5'd8;
    else if (env >= 8'h06)            d = 5'd16;
    else if (env >= 8'h01)            d = 5'd30;
    else                              d = 5'd1;
    return d;
  endfunction

endpackage

// File: rtl/sid_envelope_step.sv
// Combinational next-state of one envelope voice, shared by all time slots.
// Ports: cfg (voice register), state/env/prev_gate/rate_cnt/exp_cnt (current
// voice state) in; nxt_state/nxt_env/nxt_rate_cnt/nxt_exp_cnt out.
module sid_envelope_step
  import sid::*;
#(
  parameter int RATE_W = 15,
  parameter int EXP_W  = 5
) (
  input  envelope_reg_t     cfg,
  input  env_state_t        state,
  input  logic              prev_gate,
  input  logic [7:0]        env,
  input  logic [RATE_W-1:0] rate_cnt,
  input  logic [EXP_W-1:0]  exp_cnt,
  output env_state_t        nxt_state,
  output logic [7:0]        nxt_env,
  output logic [RATE_W-1:0] nxt_rate_cnt,
  output logic [EXP_W-1:0]  nxt_exp_cnt
);

  logic [3:0]  rate_idx;
  logic [15:0] period;
  logic        rate_evt;
  logic        do_step;
  logic [4:0]  div;

  always_comb begin
    nxt_state    = state;
    rate_idx     = cfg.release_;
    period       = 16'd0;
    rate_evt     = 1'b0;
    nxt_rate_cnt = rate_cnt + RATE_W'(1);
    div          = 5'd1;
    do_step      = 1'b0;
    nxt_exp_cnt  = exp_cnt;
    nxt_env      = env;

    // 1) state transition
    if (cfg.gate && !prev_gate)
      nxt_state = ATTACK;
    else if (!cfg.gate)
      nxt_state = RELEASE;
    else if (state == ATTACK && env == 8'hFF)
      nxt_state = DECAY_SUSTAIN;

    // 2) rate index follows the new state
    case (nxt_state)
      ATTACK:        rate_idx = cfg.attack;
      DECAY_SUSTAIN: rate_idx = cfg.decay;
      default:       rate_idx = cfg.release_;
    endcase
    period = ENV_RATE_PERIOD[rate_idx];

    // 3) rate compare; the counter is never cleared on a gate change, and it
    //    wraps one short of its full range so a missed period costs a full
    //    lap (the original chip's ADSR delay bug).
    if (32'(rate_cnt) == 32'(period)) begin
      nxt_rate_cnt = '0;
      rate_evt     = 1'b1;
    end else if (rate_cnt == RATE_W'(32766)) begin
      nxt_rate_cnt = '0;
    end

    // 4) exponential prescale and envelope step
    div = exp_divisor(nxt_state, env);
    if (rate_evt) begin
      if (6'(exp_cnt) + 6'd1 >= 6'(div)) begin
        nxt_exp_cnt = '0;
        do_step     = 1'b1;
      end else begin
        nxt_exp_cnt = exp_cnt + EXP_W'(1);
      end
    end

    // Decrements stop at 00, so env stays frozen there until a rising gate
    // puts the voice back into ATTACK.
    if (do_step) begin
      case (nxt_state)
        ATTACK: begin
          if (env != 8'hFF) nxt_env = env + 8'd1;
        end
        DECAY_SUSTAIN: begin
          if (env != {cfg.sustain, cfg.sustain} && env != 8'h00) nxt_env = env - 8'd1;
        end
        default: begin
          if (env != 8'h00) nxt_env = env - 8'd1;
        end
      endcase
    end
  end

endmodule

// File: rtl/sid_envelope_mv.sv
// Time-multiplexed SID ADSR envelope generator: each tick sweeps all voices,
// one voice per clk, through a shared step block.
// Ports: clk, res_n, tick in; reg_i per-voice config in; env_o per-voice
// envelope out; busy (sweep active), done (sweep end pulse), overrun (sticky).
module sid_envelope_mv
  import sid::*;
#(
  parameter int VOICES = 3,
  parameter int RATE_W = 15,
  parameter int EXP_W  = 5
) (
  input  logic                           clk,
  input  logic                           res_n,
  input  logic                           tick,
  input  envelope_reg_t [VOICES-1:0]     reg_i,
  output logic          [VOICES-1:0][7:0] env_o,
  output logic                           busy,
  output logic                           done,
  output logic                           overrun
);

  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  seq_state_t       seq_q, seq_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_d;

  logic [7:0]        env_q       [VOICES];
  env_state_t        state_q     [VOICES];
  logic              prev_gate_q [VOICES];
  logic [RATE_W-1:0] rate_q      [VOICES];
  logic [EXP_W-1:0]  exp_q       [VOICES];

  envelope_reg_t     cur_cfg;
  env_state_t        nxt_state;
  logic [7:0]        nxt_env;
  logic [RATE_W-1:0] nxt_rate_cnt;
  logic [EXP_W-1:0]  nxt_exp_cnt;

  assign busy = (seq_q == SEQ_RUN);

  // Sequencer
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      seq_q   <= SEQ_IDLE;
      idx_q   <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      seq_q <= seq_d;
      idx_q <= idx_d;
      done  <= done_d;
      // A tick during a sweep is dropped; remember that it happened.
      if (tick && busy) overrun <= 1'b1;
    end
  end

  always_comb begin
    seq_d  = seq_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    case (seq_q)
      SEQ_IDLE: begin
        if (tick) begin
          seq_d = SEQ_RUN;
          idx_d = '0;
        end
      end
      SEQ_RUN: begin
        if (idx_q == IDX_W'(VOICES - 1)) begin
          seq_d  = SEQ_IDLE;
          idx_d  = '0;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: begin
        seq_d = SEQ_IDLE;
        idx_d = '0;
      end
    endcase
  end

  // Addressed voice through the shared step logic
  assign cur_cfg = reg_i[idx_q];

  sid_envelope_step #(
    .RATE_W (RATE_W),
    .EXP_W  (EXP_W)
  ) u_step (
    .cfg          (cur_cfg),
    .state        (state_q[idx_q]),
    .prev_gate    (prev_gate_q[idx_q]),
    .env          (env_q[idx_q]),
    .rate_cnt     (rate_q[idx_q]),
    .exp_cnt      (exp_q[idx_q]),
    .nxt_state    (nxt_state),
    .nxt_env      (nxt_env),
    .nxt_rate_cnt (nxt_rate_cnt),
    .nxt_exp_cnt  (nxt_exp_cnt)
  );

  // Voice state: only the slot's voice is written, the rest hold.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int v = 0; v < VOICES; v++) begin
        env_q[v]       <= 8'h00;
        state_q[v]     <= RELEASE;
        prev_gate_q[v] <= 1'b0;
        rate_q[v]      <= '0;
        exp_q[v]       <= '0;
      end
    end else if (busy) begin
      env_q[idx_q]       <= nxt_env;
      state_q[idx_q]     <= nxt_state;
      prev_gate_q[idx_q] <= cur_cfg.gate;
      rate_q[idx_q]      <= nxt_rate_cnt;
      exp_q[idx_q]       <= nxt_exp_cnt;
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_env_out
    assign env_o[v] = env_q[v];
  end

endmodule

// File: doc/sid_envelope_mv.md
SID_ENVELOPE_MV -- requirements
Module: sid_envelope_mv

Interface
REQ-001 SHALL have parameter VOICES, default 3, number of time-multiplexed envelope voices, legal 1..8.
REQ-002 SHALL have parameter RATE_W, default 15, rate counter width, legal 15..16.
REQ-003 SHALL have parameter EXP_W, default 5, exponential counter width, fixed at 5.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port res_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port tick, input, 1 bit: one-clk strobe, one SID cycle elapsed.
REQ-007 SHALL have port reg_i, input, VOICES x sid::envelope_reg_t: per-voice gate, attack, decay, sustain and release_.
REQ-008 SHALL have port env_o, output, VOICES x 8 bits: per-voice envelope value.
REQ-009 SHALL have port busy, output, 1 bit: high while the voice sweep is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-clk pulse when the sweep completes.
REQ-011 SHALL have port overrun, output, 1 bit: sticky; set when tick is dropped.

Function
REQ-012 SHALL run a sequencer with two states:
- IDLE -> RUN on tick; voice index = 0.
- RUN: one voice per clk, index 0..VOICES-1.
- RUN -> IDLE after the last voice; done pulses the following clk.
REQ-013 SHALL keep busy = 1 exactly for the VOICES clks of RUN.
REQ-014 SHALL ignore a tick arriving while busy = 1 and set overrun = 1; overrun clears only on reset.
REQ-015 SHALL keep per voice: env (8 bits), state {ATTACK, DECAY_SUSTAIN, RELEASE}, prev_gate, rate_cnt (RATE_W bits), exp_cnt (EXP_W bits).
REQ-016 SHALL update only the addressed voice in its slot; all other voices hold.
REQ-017 SHALL sample gate in the voice's slot, with these transitions:
- Rising gate (gate = 1, prev_gate = 0) -> ATTACK.
- gate = 0 -> RELEASE.
- ATTACK and env becomes FF -> DECAY_SUSTAIN.
REQ-018 SHALL select the rate index from the new state: ATTACK -> attack, DECAY_SUSTAIN -> decay, RELEASE -> release_.
REQ-019 SHALL compare rate_cnt with sid::ENV_RATE_PERIOD[index]:
- Table values: 8, 31, 62, 94, 148, 219, 266, 312, 391, 976, 1953, 3125, 3906, 11719, 19531, 31250.
- On equality: rate_cnt -> 0 and a rate event is generated.
- Otherwise: rate_cnt increments.
- rate_cnt SHALL wrap 32766 -> 0, which reproduces the ADSR delay bug.
REQ-020 SHALL NOT reset rate_cnt on a gate change.
REQ-021 SHALL use an exponential divisor D, computed combinationally from env:
- ATTACK, or env >= 5D: D = 1
- 36..5C: D = 2
- 1A..35: D = 4
- 0E..19: D = 8
- 06..0D: D = 16
- 01..05: D = 30
- 00: D = 1
REQ-022 SHALL handle a rate event as follows:
- If exp_cnt + 1 >= D: exp_cnt -> 0 and env steps.
- Otherwise: exp_cnt increments.
REQ-023 SHALL step env as follows:
- ATTACK: +1, saturating at FF.
- DECAY_SUSTAIN: -1, but not when env == {sustain, sustain}.
- RELEASE: -1, saturating at 00.
- env SHALL never wrap.
REQ-024 SHALL freeze env at 00 until the next rising gate; the rate and exp counters keep running.
REQ-025 SHALL make a sustain change take effect in the next slot of that voice; if env is already below the new level, env keeps decaying to 00.
REQ-026 SHALL handle simultaneous events in one slot in this order: state transition, then index selection, then rate compare, then step.
REQ-027 SHALL make env_o[v] valid from the clk after voice v's slot, with 1 clk latency.

Reset
REQ-028 SHALL, on res_n = 0, asynchronously clear:
- every env, rate_cnt, exp_cnt and prev_gate to 0;
- every state to RELEASE;
- the sequencer to IDLE;
- busy, done and overrun to 0.
REQ-029 SHALL, on res_n = 0 mid-sweep, abort the sweep without a done pulse.
REQ-030 SHALL make the first tick after reset release start a full sweep from voice 0.

Structure
REQ-031 SHALL place env_state_t, ENV_RATE_PERIOD and the exponential-divisor function in package sid.
REQ-032 SHALL implement the per-voice next-state computation as one combinational sub-module, sid_envelope_step, shared by all slots; voice state SHALL be held in register arrays in the parent.

Verification
REQ-033 SHALL cover attack: VOICES = 3, voice 0 attack = 0, gate rises -> env reaches FF after 255 x 9 = 2295 ticks, then DECAY_SUSTAIN.
REQ-034 SHALL cover sustain: decay = 0, sustain = A after FF -> env holds at AA while the gate stays high; voices 1 and 2 stay at 00.
REQ-035 SHALL cover release: gate falls at env = AA with release = 0 -> env reaches 00 in exactly the tick count implied by REQ-021, then stays 00 for 10000 further ticks.
REQ-036 SHALL cover overrun: tick reasserted 1 clk after the sweep starts -> overrun = 1, exactly one done pulse, env unchanged by the second tick.
REQ-037 SHALL cover reset mid-sweep: res_n = 0 while busy with env = 80 -> env_o = 0 and busy = 0 before the next clk edge, and no done pulse.
